// File: rtl/rom_burst_reader.sv
// Burst read master for a registered-output dual-port ROM: reads word pairs per cycle,
// packs them into beats and streams them out through a credit-protected FWFT FIFO.
module rom_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH:0]     burst_len,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   rom_addr_a,
  output logic                    rom_read_en_a,
  input  logic [DATA_WIDTH-1:0]   rom_data_a,
  output logic [ADDR_WIDTH-1:0]   rom_addr_b,
  output logic                    rom_read_en_b,
  input  logic [DATA_WIDTH-1:0]   rom_data_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic [1:0]              out_keep,
  output logic                    out_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic                    last;
    logic [1:0]              keep;
    logic [2*DATA_WIDTH-1:0] data;
  } beat_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  done_zero_q;
  logic                  inflight_q, inflight_hi_q, inflight_last_q;
  logic                  issue, issue_b, issue_last, drain_done;

  beat_t                 fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W:0]        used_slots;
  logic                  credit_ok, push, pop, fifo_full;
  beat_t                 push_beat, head_beat;

  // Every slot already buffered or about to land from the ROM consumes a credit.
  assign used_slots = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok  = used_slots < (CNT_W+1)'(FIFO_DEPTH);
  assign fifo_full  = count_q == CNT_W'(FIFO_DEPTH);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    issue      = 1'b0;
    issue_b    = 1'b0;
    issue_last = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d = start_addr;
          rem_d = burst_len;
          if (burst_len != '0) state_d = READ;
        end
      end
      READ: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_b    = rem_q >= (ADDR_WIDTH+1)'(2);
          issue_last = rem_q <= (ADDR_WIDTH+1)'(2);
          cur_d      = cur_q + ADDR_WIDTH'(2);
          rem_d      = issue_b ? rem_q - (ADDR_WIDTH+1)'(2) : '0;
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && count_q == '0) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cur_q           <= '0;
      rem_q           <= '0;
      done_zero_q     <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_hi_q   <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_q           <= cur_d;
      rem_q           <= rem_d;
      done_zero_q     <= (state_q == IDLE) && start && (burst_len == '0);
      inflight_q      <= issue;
      inflight_hi_q   <= issue_b;
      inflight_last_q <= issue_last;
    end
  end

  assign busy          = state_q != IDLE;
  assign done          = done_zero_q | drain_done;
  assign rom_read_en_a = issue;
  assign rom_read_en_b = issue_b;
  // Addresses follow cur while busy, so they hold whenever no credit is available.
  assign rom_addr_a    = busy ? cur_q : '0;
  assign rom_addr_b    = busy ? cur_q + ADDR_WIDTH'(1) : '0;

  // ROM data arrives one cycle after issue and is written straight into the FIFO.
  assign push           = inflight_q;
  assign pop            = out_valid & out_ready;
  assign push_beat.last = inflight_last_q;
  assign push_beat.keep = {inflight_hi_q, 1'b1};
  assign push_beat.data = {(inflight_hi_q ? rom_data_b : {DATA_WIDTH{1'b0}}), rom_data_a};

  // NOTE: the storage array has no reset; only pointers and count need a known value.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_beat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_beat = fifo_mem[rd_ptr_q];
  assign out_valid = count_q != '0;
  assign out_data  = out_valid ? head_beat.data : '0;
  assign out_keep  = out_valid ? head_beat.keep : '0;
  assign out_last  = out_valid ? head_beat.last : 1'b0;

  // The credit scheme must never let a push land on a full FIFO without a pop.
  fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && fifo_full && !pop));

endmodule
